// File: rtl/alu_seq_unit_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, FSM state type and
// a helper that classifies opcodes handled by the iterative multiply/divide unit.
package alu_seq_unit_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLL   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_MUL   = 4'b1010;
    localparam logic [3:0] ALU_MULHU = 4'b1011;
    localparam logic [3:0] ALU_DIVU  = 4'b1100;
    localparam logic [3:0] ALU_REMU  = 4'b1101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } alu_state_e;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op >= ALU_MUL) && (op <= ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_seq_unit_if.sv
// Operand/result handshake bundle of the sequential ALU.
//  master: producer of operands and consumer of results (pipeline side)
//  slave : the ALU itself
interface alu_seq_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_control;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output in_valid, a, b, alu_control, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, a, b, alu_control, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide engine, one step per cycle for WIDTH cycles.
//  clk, rst  : clock, async active-high reset
//  abort_i   : drop the in-flight operation
//  start_i   : load op/operands and begin (counter = WIDTH)
//  op_i      : MUL, MULHU, DIVU or REMU
//  a_i, b_i  : operands
//  busy_o    : an operation is in progress
//  done_o    : the step taken on the coming edge is the last one
//  result_o  : value the last step produces (valid while done_o)
module alu_muldiv_iter
    import alu_seq_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort_i,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);
    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    logic [CntW-1:0]      cnt_q, cnt_d;
    // Multiply: {partial high, multiplier shifting out}. Divide: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;   // multiplicand for MUL*, divisor for DIV*
    logic                 div_q, div_d;
    logic                 hi_q, hi_d;       // result taken from upper half of acc

    logic                 start_div, start_hi;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   step;

    assign start_div = (op_i == ALU_DIVU) || (op_i == ALU_REMU);
    assign start_hi  = (op_i == ALU_MULHU) || (op_i == ALU_REMU);

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge    = div_shift >= {1'b0, opnd_q};
        // Remainder stays below the divisor, so the subtraction fits in WIDTH bits.
        // A zero divisor always "fits": quotient all ones, remainder ends up equal to a.
        div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
        step      = div_q ? {div_rem, acc_q[WIDTH-2:0], div_ge}
                          : {mul_sum, acc_q[WIDTH-1:1]};
    end

    assign busy_o   = (cnt_q != '0);
    assign done_o   = (cnt_q == CntW'(1));
    assign result_o = hi_q ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        opnd_d = opnd_q;
        div_d  = div_q;
        hi_d   = hi_q;
        if (abort_i) begin
            cnt_d = '0;
        end else if (start_i) begin
            cnt_d  = CntW'(WIDTH);
            div_d  = start_div;
            hi_d   = start_hi;
            opnd_d = start_div ? b_i : a_i;
            acc_d  = {{WIDTH{1'b0}}, (start_div ? a_i : b_i)};
        end else if (busy_o) begin
            cnt_d = cnt_q - CntW'(1);
            acc_d = step;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            hi_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            div_q  <= div_d;
            hi_q   <= hi_d;
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Multi-cycle execute-stage ALU with registered result and valid/ready on both sides.
// Single-cycle ops complete one edge after accept; MUL/MULHU/DIVU/REMU go through
// alu_muldiv_iter and complete WIDTH+1 cycles after accept.
//  clk     : clock, rising edge
//  rst     : asynchronous active-high reset
//  flush   : synchronous abort; blocks acceptance in the same cycle
//  alu_io  : operand/result handshake (in_valid/in_ready/a/b/alu_control,
//            out_valid/out_ready/result/zero)
module alu_seq_unit
    import alu_seq_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    alu_seq_unit_if.slave  alu_io
);
    localparam int unsigned ShamtW = $clog2(WIDTH);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    logic              accept;
    logic              start_iter;
    logic [ShamtW-1:0] shamt;
    logic [WIDTH-1:0]  single_res;
    logic              iter_busy, iter_done;
    logic [WIDTH-1:0]  iter_res;

    assign alu_io.in_ready  = !rst && !flush &&
                              ((state_q == StIdle) || ((state_q == StDone) && alu_io.out_ready));
    assign accept           = alu_io.in_valid && alu_io.in_ready;
    assign start_iter       = accept && is_multicycle(alu_io.alu_control);
    assign alu_io.out_valid = (state_q == StDone);
    assign alu_io.result    = result_q;
    assign alu_io.zero      = zero_q;

    assign shamt = alu_io.b[ShamtW-1:0];

    always_comb begin
        single_res = '0;
        case (alu_io.alu_control)
            ALU_ADD:  single_res = alu_io.a + alu_io.b;
            ALU_SUB:  single_res = alu_io.a - alu_io.b;
            ALU_AND:  single_res = alu_io.a & alu_io.b;
            ALU_OR:   single_res = alu_io.a | alu_io.b;
            ALU_XOR:  single_res = alu_io.a ^ alu_io.b;
            ALU_SLL:  single_res = alu_io.a << shamt;
            ALU_SRL:  single_res = alu_io.a >> shamt;
            ALU_SRA:  single_res = $unsigned($signed(alu_io.a) >>> shamt);
            ALU_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(alu_io.a) < $signed(alu_io.b))};
            ALU_SLTU: single_res = {{(WIDTH-1){1'b0}}, (alu_io.a < alu_io.b)};
            default:  single_res = '0;  // reserved opcodes
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .abort_i  (flush),
        .start_i  (start_iter),
        .op_i     (alu_io.alu_control),
        .a_i      (alu_io.a),
        .b_i      (alu_io.b),
        .busy_o   (iter_busy),
        .done_o   (iter_done),
        .result_o (iter_res)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if ((state_q == StDone) && alu_io.out_ready) begin
                        state_d = StIdle;
                    end
                    // Accept from DONE only happens while the old result is consumed.
                    if (accept) begin
                        if (is_multicycle(alu_io.alu_control)) begin
                            state_d = StBusy;
                        end else begin
                            state_d  = StDone;
                            result_d = single_res;
                            zero_d   = (single_res == '0);
                        end
                    end
                end
                StBusy: begin
                    if (iter_done) begin
                        state_d  = StDone;
                        result_d = iter_res;
                        zero_d   = (iter_res == '0);
                    end else if (!iter_busy) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
module tb_alu_seq_unit;
    logic clk;
    logic rst;
    logic flush;
    int   n_cmp;
    int   n_bad;

    alu_seq_unit_if #(.WIDTH(32)) bus ();

    alu_seq_unit #(
        .WIDTH (32)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .alu_io (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issue one op from IDLE, count edges from accept to out_valid, then consume it.
    // While waiting, a junk ADD is presented to show it is ignored.
    task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         output int lat, output logic [31:0] res, output logic z,
                         output logic rdy_seen);
        bus.in_valid    = 1'b1;
        bus.alu_control = op;
        bus.a           = av;
        bus.b           = bv;
        @(negedge clk);
        lat      = 1;
        rdy_seen = 1'b0;
        bus.alu_control = 4'b0000;
        bus.a           = 32'h1;
        bus.b           = 32'h1;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        res = bus.result;
        z   = bus.zero;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++;
            $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.result !== 32'h0) begin n_bad++;
            $display("FAIL reset result: got %h want 00000000", bus.result); end
        n_cmp++; if (bus.zero !== 1'b1) begin n_bad++;
            $display("FAIL reset zero: got %b want 1", bus.zero); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++;
            $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [3:0]  ops [7] = '{4'b0101, 4'b0111, 4'b1000, 4'b1001, 4'b0110, 4'b0100, 4'b1110};
        logic [31:0] av  [7] = '{32'h00000001, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'h80000000, 32'hF0F0F0F0, 32'h00000012};
        logic [31:0] bv  [7] = '{32'd4, 32'd4, 32'd1, 32'd1, 32'd4, 32'hFF00FF00, 32'h34};
        logic [31:0] ex  [7] = '{32'h00000010, 32'hF8000000, 32'h00000001, 32'h00000000,
                                 32'h08000000, 32'h0FF00FF0, 32'h00000000};
        int lat; logic [31:0] res; logic z; logic rdy;
        for (int i = 0; i < 7; i++) begin
            issue(ops[i], av[i], bv[i], lat, res, z, rdy);
            n_cmp++; if (res !== ex[i]) begin n_bad++;
                $display("FAIL single op %b result: got %h want %h", ops[i], res, ex[i]); end
            n_cmp++; if (z !== (ex[i] == 32'h0)) begin n_bad++;
                $display("FAIL single op %b zero: got %b want %b", ops[i], z, ex[i] == 0); end
            n_cmp++; if (lat !== 1) begin n_bad++;
                $display("FAIL single op %b latency: got %0d want 1", ops[i], lat); end
        end
    endtask

    task automatic test_muldiv();
        logic [3:0]  ops [8] = '{4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1100, 4'b1101,
                                 4'b1010, 4'b1011};
        logic [31:0] av  [8] = '{32'h00010000, 32'h00010000, 32'd100, 32'd100, 32'd5, 32'd5,
                                 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bv  [8] = '{32'h00010000, 32'h00010000, 32'd7, 32'd7, 32'd0, 32'd0,
                                 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ex  [8] = '{32'h00000000, 32'h00000001, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5,
                                 32'h00000001, 32'hFFFFFFFE};
        int lat; logic [31:0] res; logic z; logic rdy;
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], av[i], bv[i], lat, res, z, rdy);
            n_cmp++; if (res !== ex[i]) begin n_bad++;
                $display("FAIL muldiv op %b result: got %h want %h", ops[i], res, ex[i]); end
            n_cmp++; if (z !== (ex[i] == 32'h0)) begin n_bad++;
                $display("FAIL muldiv op %b zero: got %b want %b", ops[i], z, ex[i] == 0); end
            n_cmp++; if (lat !== 33) begin n_bad++;
                $display("FAIL muldiv op %b latency: got %0d want 33", ops[i], lat); end
            n_cmp++; if (rdy !== 1'b0) begin n_bad++;
                $display("FAIL muldiv op %b in_ready in BUSY: got %b want 0", ops[i], rdy); end
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++;
                $display("FAIL muldiv op %b busy input queued: got out_valid %b want 0",
                         ops[i], bus.out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bus.in_valid = 1'b1; bus.alu_control = 4'b0000; bus.a = 32'd3; bus.b = 32'd4;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd7) begin n_bad++;
                $display("FAIL hold cycle %0d: got valid %b result %h want 1 00000007",
                         i, bus.out_valid, bus.result); end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.alu_control = 4'b0001; bus.a = 32'd3; bus.b = 32'd4;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++;
            $display("FAIL b2b in_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.result !== 32'hFFFFFFFF || bus.zero !== 1'b0)
        begin n_bad++;
            $display("FAIL b2b sub: got valid %b result %h zero %b want 1 ffffffff 0",
                     bus.out_valid, bus.result, bus.zero); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n = 0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++;
            $display("FAIL b2b consume: got out_valid %b want 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        int seen; int lat; logic [31:0] res; logic z; logic rdy;
        bus.in_valid = 1'b1; bus.alu_control = 4'b1100; bus.a = 32'd100; bus.b = 32'd7;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        bus.in_valid = 1'b1; bus.alu_control = 4'b0000; bus.a = 32'd5; bus.b = 32'd5;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++;
            $display("FAIL flush in_ready: got %b want 0", bus.in_ready); end
        @(negedge clk);
        flush = 1'b0; bus.in_valid = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++;
            $display("FAIL flush idle: got valid %b ready %b want 0 1",
                     bus.out_valid, bus.in_ready); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++;
            $display("FAIL flush discard: got %0d valid cycles want 0", seen); end
        issue(4'b0000, 32'd1, 32'd1, lat, res, z, rdy);
        n_cmp++; if (res !== 32'd2 || lat !== 1) begin n_bad++;
            $display("FAIL flush next add: got %h lat %0d want 00000002 lat 1", res, lat); end
    endtask

    task automatic test_async_reset();
        int seen; int lat; logic [31:0] res; logic z; logic rdy;
        bus.in_valid = 1'b1; bus.alu_control = 4'b1010; bus.a = 32'd7; bus.b = 32'd6;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.zero !== 1'b1)
        begin n_bad++;
            $display("FAIL async reset: got valid %b result %h zero %b want 0 00000000 1",
                     bus.out_valid, bus.result, bus.zero); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++;
            $display("FAIL async reset in_ready: got %b want 1", bus.in_ready); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++;
            $display("FAIL async reset discard: got %0d valid cycles want 0", seen); end
        issue(4'b0000, 32'd2, 32'd3, lat, res, z, rdy);
        n_cmp++; if (res !== 32'd5) begin n_bad++;
            $display("FAIL async reset next add: got %h want 00000005", res); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        flush = 1'b0;
        rst   = 1'b0;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.alu_control = 4'b0000;
        bus.a           = 32'h0;
        bus.b           = 32'h0;
        #2 rst = 1'b1;
        test_reset();
        test_single();
        test_muldiv();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
